multicycle_ctrl: RTL and testbench



---
 rtl/mc_pkg.sv | 106 ++++++++++
 rtl/mc_outdec.sv | 118 +++++++++++
 rtl/multicycle_ctrl.sv | 80 ++++++++
 tb/tb_multicycle_ctrl.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
// Shared types and encodings for the multicycle MIPS main control FSM:
// state codes, opcode/funct values, ALUop codes, mux selects and control word.
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADR  = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_RTYPE_EX = 4'd6,
    S_RTYPE_WB = 4'd7,
    S_BEQ_EX   = 4'd8,
    S_IMM_EX   = 4'd9,
    S_IMM_WB   = 4'd10,
    S_J_EX     = 4'd11,
    S_JR_EX    = 4'd12
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_SLT  = 6'h2A;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;
  localparam logic [1:0] ALU_OR    = 2'b11;

  localparam logic [1:0] RDST_RT = 2'd0;
  localparam logic [1:0] RDST_RD = 2'd1;
  localparam logic [1:0] RDST_RA = 2'd2;

  localparam logic [1:0] M2R_ALUOUT = 2'd0;
  localparam logic [1:0] M2R_MDR    = 2'd1;
  localparam logic [1:0] M2R_PC     = 2'd2;

  localparam logic [1:0] SRCA_PC    = 2'd0;
  localparam logic [1:0] SRCA_A     = 2'd1;
  localparam logic [1:0] SRCA_SHAMT = 2'd2;

  localparam logic [1:0] SRCB_B     = 2'd0;
  localparam logic [1:0] SRCB_FOUR  = 2'd1;
  localparam logic [1:0] SRCB_EXT   = 2'd2;
  localparam logic [1:0] SRCB_BROFS = 2'd3;

  localparam logic [1:0] EXT_SIGN = 2'd0;
  localparam logic [1:0] EXT_ZERO = 2'd1;
  localparam logic [1:0] EXT_LUI  = 2'd2;

  localparam logic [1:0] PCS_ALU    = 2'd0;
  localparam logic [1:0] PCS_ALUOUT = 2'd1;
  localparam logic [1:0] PCS_JUMP   = 2'd2;
  localparam logic [1:0] PCS_REG    = 2'd3;

  typedef struct packed {
    logic       pc_en;
    logic       ir_write;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] ext_op;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       illegal;
    logic       instr_done;
  } ctrl_t;

  // DECODE dispatch; S_FETCH doubles as the "unsupported instruction" answer.
  function automatic state_e decode_next(input logic [5:0] op, input logic [5:0] funct);
    state_e nxt;
    nxt = S_FETCH;
    case (op)
      OP_LW, OP_SW:   nxt = S_MEM_ADR;
      OP_BEQ:         nxt = S_BEQ_EX;
      OP_ORI, OP_LUI: nxt = S_IMM_EX;
      OP_J, OP_JAL:   nxt = S_J_EX;
      OP_RTYPE: begin
        case (funct)
          FN_JR:                                  nxt = S_JR_EX;
          FN_ADDU, FN_SUBU, FN_SLT, FN_SLL:       nxt = S_RTYPE_EX;
          default:                                nxt = S_FETCH;
        endcase
      end
      default:        nxt = S_FETCH;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/mc_outdec.sv
// Moore output decoder: registered state (plus the few qualifying inputs)
// to the datapath control word.
module mc_outdec
  import mc_pkg::*;
(
  input  state_e      state_i,
  input  logic [5:0]  op_i,
  input  logic [5:0]  funct_i,
  input  logic        zero_i,
  input  logic        mem_ready_i,
  input  logic        rst_n,
  output ctrl_t       ctrl_o
);

  always_comb begin
    // NOTE: zeroing the whole word first keeps every field assigned on every path, so no latches.
    ctrl_o = '0;
    case (state_i)
      S_FETCH: begin
        ctrl_o.mem_read  = 1'b1;
        ctrl_o.alu_src_a = SRCA_PC;
        ctrl_o.alu_src_b = SRCB_FOUR;
        ctrl_o.alu_op    = ALU_ADD;
        ctrl_o.ir_write  = mem_ready_i;
        ctrl_o.pc_en     = mem_ready_i;
      end
      S_DECODE: begin
        ctrl_o.alu_src_a = SRCA_PC;
        ctrl_o.alu_src_b = SRCB_BROFS;
        ctrl_o.alu_op    = ALU_ADD;
        if (decode_next(op_i, funct_i) == S_FETCH) begin
          ctrl_o.illegal    = 1'b1;
          ctrl_o.instr_done = 1'b1;
        end
      end
      S_MEM_ADR: begin
        ctrl_o.alu_src_a = SRCA_A;
        ctrl_o.alu_src_b = SRCB_EXT;
        ctrl_o.ext_op    = EXT_SIGN;
        ctrl_o.alu_op    = ALU_ADD;
      end
      S_MEM_RD: begin
        ctrl_o.mem_read = 1'b1;
        ctrl_o.i_or_d   = 1'b1;
      end
      S_MEM_WB: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.reg_dst    = RDST_RT;
        ctrl_o.mem_to_reg = M2R_MDR;
        ctrl_o.instr_done = 1'b1;
      end
      S_MEM_WR: begin
        ctrl_o.mem_write  = 1'b1;
        ctrl_o.i_or_d     = 1'b1;
        ctrl_o.instr_done = mem_ready_i;
      end
      S_RTYPE_EX: begin
        ctrl_o.alu_src_a = (funct_i == FN_SLL) ? SRCA_SHAMT : SRCA_A;
        ctrl_o.alu_src_b = SRCB_B;
        ctrl_o.alu_op    = ALU_FUNCT;
      end
      S_RTYPE_WB: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.reg_dst    = RDST_RD;
        ctrl_o.mem_to_reg = M2R_ALUOUT;
        ctrl_o.instr_done = 1'b1;
      end
      S_BEQ_EX: begin
        ctrl_o.alu_src_a  = SRCA_A;
        ctrl_o.alu_src_b  = SRCB_B;
        ctrl_o.alu_op     = ALU_SUB;
        ctrl_o.pc_source  = PCS_ALUOUT;
        ctrl_o.pc_en      = zero_i;
        ctrl_o.instr_done = 1'b1;
      end
      S_IMM_EX: begin
        ctrl_o.alu_src_a = SRCA_A;
        ctrl_o.alu_src_b = SRCB_EXT;
        ctrl_o.alu_op    = ALU_OR;
        ctrl_o.ext_op    = (op_i == OP_LUI) ? EXT_LUI : EXT_ZERO;
      end
      S_IMM_WB: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.reg_dst    = RDST_RT;
        ctrl_o.mem_to_reg = M2R_ALUOUT;
        ctrl_o.instr_done = 1'b1;
      end
      S_J_EX: begin
        ctrl_o.pc_source  = PCS_JUMP;
        ctrl_o.pc_en      = 1'b1;
        ctrl_o.instr_done = 1'b1;
        if (op_i == OP_JAL) begin
          ctrl_o.reg_write  = 1'b1;
          ctrl_o.reg_dst    = RDST_RA;
          ctrl_o.mem_to_reg = M2R_PC;
        end
      end
      S_JR_EX: begin
        ctrl_o.pc_source  = PCS_REG;
        ctrl_o.pc_en      = 1'b1;
        ctrl_o.instr_done = 1'b1;
      end
      default: ctrl_o = '0;
    endcase

    // Reset is synchronous, so the state may still be mid-instruction; block all side effects.
    if (!rst_n) begin
      ctrl_o.pc_en      = 1'b0;
      ctrl_o.ir_write   = 1'b0;
      ctrl_o.mem_read   = 1'b0;
      ctrl_o.mem_write  = 1'b0;
      ctrl_o.reg_write  = 1'b0;
      ctrl_o.illegal    = 1'b0;
      ctrl_o.instr_done = 1'b0;
    end
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multicycle MIPS core: state register, next-state
// logic and the output decoder that drives the shared datapath.
module multicycle_ctrl
  import mc_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_en,
  output logic       ir_write,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       reg_write,
  output logic [1:0] reg_dst,
  output logic [1:0] mem_to_reg,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] ext_op,
  output logic [1:0] alu_op,
  output logic [1:0] pc_source,
  output logic       illegal,
  output logic       instr_done,
  output logic [3:0] state
);

  state_e state_q, state_d;
  ctrl_t  ctrl;

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:    state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE:   state_d = decode_next(op, funct);
      S_MEM_ADR:  state_d = (op == OP_SW) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:   state_d = mem_ready ? S_MEM_WB : S_MEM_RD;
      S_MEM_WR:   state_d = mem_ready ? S_FETCH : S_MEM_WR;
      S_RTYPE_EX: state_d = S_RTYPE_WB;
      S_IMM_EX:   state_d = S_IMM_WB;
      default:    state_d = S_FETCH;
    endcase
  end

  // NOTE: state is sequential, so it uses non-blocking assignment; reset is sampled on the clock edge.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  mc_outdec u_outdec (
    .state_i     (state_q),
    .op_i        (op),
    .funct_i     (funct),
    .zero_i      (zero),
    .mem_ready_i (mem_ready),
    .rst_n       (rst_n),
    .ctrl_o      (ctrl)
  );

  assign pc_en      = ctrl.pc_en;
  assign ir_write   = ctrl.ir_write;
  assign i_or_d     = ctrl.i_or_d;
  assign mem_read   = ctrl.mem_read;
  assign mem_write  = ctrl.mem_write;
  assign reg_write  = ctrl.reg_write;
  assign reg_dst    = ctrl.reg_dst;
  assign mem_to_reg = ctrl.mem_to_reg;
  assign alu_src_a  = ctrl.alu_src_a;
  assign alu_src_b  = ctrl.alu_src_b;
  assign ext_op     = ctrl.ext_op;
  assign alu_op     = ctrl.alu_op;
  assign pc_source  = ctrl.pc_source;
  assign illegal    = ctrl.illegal;
  assign instr_done = ctrl.instr_done;
  assign state      = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: each instruction is expanded into
// its expected per-cycle trace from the instruction class and stall plan.
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] op, funct;
  logic       zero, mem_ready;
  logic       pc_en, ir_write, i_or_d, mem_read, mem_write, reg_write;
  logic [1:0] reg_dst, mem_to_reg, alu_src_a, alu_src_b, ext_op, alu_op, pc_source;
  logic       illegal, instr_done;
  logic [3:0] state;

  int checks = 0;
  int failures = 0;

  multicycle_ctrl dut (
    .clk(clk), .rst_n(rst_n), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .pc_en(pc_en), .ir_write(ir_write), .i_or_d(i_or_d), .mem_read(mem_read),
    .mem_write(mem_write), .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .ext_op(ext_op), .alu_op(alu_op),
    .pc_source(pc_source), .illegal(illegal), .instr_done(instr_done), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] st;
    logic       pc_en, ir_write, i_or_d, mem_read, mem_write, reg_write;
    logic [1:0] reg_dst, mem_to_reg, src_a, src_b, ext_op, alu_op, pc_source;
    logic       illegal, done;
  } exp_t;

  typedef struct {
    logic mr;
    exp_t e;
  } cyc_t;

  typedef enum int {K_ILL, K_LW, K_SW, K_RTYPE, K_JR, K_BEQ, K_ORI, K_LUI, K_J, K_JAL} kind_e;

  cyc_t       q[$];
  logic [5:0] cur_op, cur_funct;
  logic       cur_zero;

  function automatic kind_e classify(input logic [5:0] o, input logic [5:0] f);
    if (o == 6'h23) return K_LW;
    if (o == 6'h2B) return K_SW;
    if (o == 6'h04) return K_BEQ;
    if (o == 6'h0D) return K_ORI;
    if (o == 6'h0F) return K_LUI;
    if (o == 6'h02) return K_J;
    if (o == 6'h03) return K_JAL;
    if (o == 6'h00 && f == 6'h08) return K_JR;
    if (o == 6'h00 && (f == 6'h21 || f == 6'h23 || f == 6'h2A || f == 6'h00)) return K_RTYPE;
    return K_ILL;
  endfunction

  function automatic exp_t blank(input int st);
    exp_t e;
    e = '0;
    e.st = 4'(st);
    return e;
  endfunction

  function automatic logic rnd_bit();
    return 1'($urandom_range(1));
  endfunction

  function automatic cyc_t mk(input logic mr, input exp_t e);
    cyc_t c;
    c.mr = mr;
    c.e  = e;
    return c;
  endfunction

  // Expected trace of one instruction. Stall counts apply to FETCH and the memory phase.
  task automatic build(input logic [5:0] o, input logic [5:0] f, input logic z,
                       input int fstall, input int mstall);
    kind_e k;
    exp_t  e;
    q.delete();
    cur_op = o; cur_funct = f; cur_zero = z;
    k = classify(o, f);

    for (int i = 0; i <= fstall; i++) begin
      e = blank(0);
      e.mem_read = 1; e.src_b = 2'd1;
      e.pc_en = (i == fstall); e.ir_write = (i == fstall);
      q.push_back(mk(i == fstall, e));
    end

    e = blank(1); e.src_b = 2'd3;
    if (k == K_ILL) begin e.illegal = 1; e.done = 1; end
    q.push_back(mk(rnd_bit(), e));

    case (k)
      K_LW, K_SW: begin
        e = blank(2); e.src_a = 2'd1; e.src_b = 2'd2;
        q.push_back(mk(rnd_bit(), e));
        for (int i = 0; i <= mstall; i++) begin
          if (k == K_LW) begin
            e = blank(3); e.mem_read = 1; e.i_or_d = 1;
          end else begin
            e = blank(5); e.mem_write = 1; e.i_or_d = 1; e.done = (i == mstall);
          end
          q.push_back(mk(i == mstall, e));
        end
        if (k == K_LW) begin
          e = blank(4); e.reg_write = 1; e.mem_to_reg = 2'd1; e.done = 1;
          q.push_back(mk(rnd_bit(), e));
        end
      end
      K_RTYPE: begin
        e = blank(6); e.src_a = (f == 6'h00) ? 2'd2 : 2'd1; e.alu_op = 2'b10;
        q.push_back(mk(rnd_bit(), e));
        e = blank(7); e.reg_write = 1; e.reg_dst = 2'd1; e.done = 1;
        q.push_back(mk(rnd_bit(), e));
      end
      K_BEQ: begin
        e = blank(8); e.src_a = 2'd1; e.alu_op = 2'b01; e.pc_source = 2'd1;
        e.pc_en = z; e.done = 1;
        q.push_back(mk(rnd_bit(), e));
      end
      K_ORI, K_LUI: begin
        e = blank(9); e.src_a = 2'd1; e.src_b = 2'd2; e.alu_op = 2'b11;
        e.ext_op = (k == K_LUI) ? 2'd2 : 2'd1;
        q.push_back(mk(rnd_bit(), e));
        e = blank(10); e.reg_write = 1; e.done = 1;
        q.push_back(mk(rnd_bit(), e));
      end
      K_J, K_JAL: begin
        e = blank(11); e.pc_source = 2'd2; e.pc_en = 1; e.done = 1;
        if (k == K_JAL) begin e.reg_write = 1; e.reg_dst = 2'd2; e.mem_to_reg = 2'd2; end
        q.push_back(mk(rnd_bit(), e));
      end
      K_JR: begin
        e = blank(12); e.pc_source = 2'd3; e.pc_en = 1; e.done = 1;
        q.push_back(mk(rnd_bit(), e));
      end
      default: ;
    endcase
  endtask

  function automatic exp_t observe();
    exp_t o;
    o.st = state; o.pc_en = pc_en; o.ir_write = ir_write; o.i_or_d = i_or_d;
    o.mem_read = mem_read; o.mem_write = mem_write; o.reg_write = reg_write;
    o.reg_dst = reg_dst; o.mem_to_reg = mem_to_reg; o.src_a = alu_src_a;
    o.src_b = alu_src_b; o.ext_op = ext_op; o.alu_op = alu_op; o.pc_source = pc_source;
    o.illegal = illegal; o.done = instr_done;
    return o;
  endfunction

  // Drives the built trace one cycle at a time; stops early after 'limit' cycles.
  task automatic run(input string name, input int limit);
    int   dones = 0;
    exp_t o;
    for (int i = 0; i < q.size() && i < limit; i++) begin
      @(negedge clk);
      mem_ready = q[i].mr; op = cur_op; funct = cur_funct; zero = cur_zero;
      #1;
      o = observe();
      checks++;
      if (o !== q[i].e) begin
        failures++;
        $display("FAIL %s cycle %0d: got state=%0d ctrl=%h, expected state=%0d ctrl=%h",
                 name, i, o.st, o, q[i].e.st, q[i].e);
      end
      if (instr_done === 1'b1) dones++;
    end
    if (limit >= q.size()) begin
      checks++;
      if (dones !== 1) begin
        failures++;
        $display("FAIL %s done_count: got %0d, expected 1", name, dones);
      end
    end
  endtask

  task automatic check_enables_off(input string name, input logic [3:0] exp_st);
    checks++;
    if (state !== exp_st || {pc_en, ir_write, mem_read, mem_write, reg_write} !== 5'b0 ||
        illegal !== 1'b0 || instr_done !== 1'b0) begin
      failures++;
      $display("FAIL %s: got state=%0d en=%b ill=%b done=%b, expected state=%0d en=00000 ill=0 done=0",
               name, state, {pc_en, ir_write, mem_read, mem_write, reg_write},
               illegal, instr_done, exp_st);
    end
  endtask

  task automatic test_reset();
    rst_n = 0; mem_ready = 0; op = 6'h23; funct = 0; zero = 0;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    check_enables_off("reset_state", 4'd0);
    rst_n = 1;
  endtask

  task automatic test_addu();
    build(6'h00, 6'h21, 0, 0, 0);
    run("addu", 1000);
  endtask

  task automatic test_lw_stall();
    build(6'h23, 6'h15, 0, 0, 2);
    run("lw_stall", 1000);
    build(6'h2B, 6'h00, 1, 1, 1);
    run("sw_stall", 1000);
  endtask

  task automatic test_beq();
    build(6'h04, 6'h00, 1, 0, 0);
    run("beq_taken", 1000);
    build(6'h04, 6'h00, 0, 0, 0);
    run("beq_not_taken", 1000);
  endtask

  task automatic test_jal_sll();
    build(6'h03, 6'h00, 0, 0, 0);
    run("jal", 1000);
    build(6'h00, 6'h00, 0, 0, 0);
    run("sll", 1000);
    build(6'h00, 6'h08, 0, 0, 0);
    run("jr", 1000);
    build(6'h0F, 6'h00, 0, 0, 0);
    run("lui", 1000);
  endtask

  task automatic test_illegal();
    build(6'h3F, 6'h00, 0, 0, 0);
    run("illegal_op", 1000);
    build(6'h00, 6'h18, 0, 0, 0);
    run("illegal_funct", 1000);
  endtask

  task automatic test_reset_mid_memrd();
    build(6'h23, 6'h00, 0, 0, 5);
    run("lw_pre_reset", 4);
    @(negedge clk);
    rst_n = 0; mem_ready = 0;
    #1;
    check_enables_off("reset_in_memrd", 4'd3);
    @(negedge clk); #1;
    check_enables_off("reset_cycle2", 4'd0);
    rst_n = 1;
    build(6'h00, 6'h23, 0, 0, 0);
    run("subu_after_reset", 1000);
  endtask

  task automatic test_back_to_back();
    logic [5:0] ops[12]   = '{6'h23, 6'h2B, 6'h04, 6'h0D, 6'h0F, 6'h02, 6'h03,
                              6'h00, 6'h00, 6'h00, 6'h00, 6'h00};
    logic [5:0] functs[12] = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00,
                               6'h21, 6'h23, 6'h2A, 6'h00, 6'h08};
    logic [5:0] o, f;
    int         sel;
    for (int n = 0; n < 200; n++) begin
      sel = $urandom_range(13);
      if (sel < 12) begin
        o = ops[sel]; f = functs[sel];
      end else begin
        o = 6'($urandom_range(63)); f = 6'($urandom_range(63));
      end
      build(o, f, rnd_bit(), $urandom_range(2), $urandom_range(3));
      run("random", 1000);
    end
  endtask

  initial begin
    test_reset();
    test_addu();
    test_lw_stall();
    test_beq();
    test_jal_sll();
    test_illegal();
    test_reset_mid_memrd();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
